bsg_lru_pseudo_tree_tracker: RTL

//  Stateful pseudo-LRU tracker for a sets_p x ways_p set-associative structure.
//  - Holds (ways_p-1) tree bits per set and updates them on touches (hits/fills).
//  - Answers registered victim queries with invalid-first and disabled-way masking.
//  - Sits beside the tag array in caches/TLBs and replaces ad-hoc encode/decode glue.

---
 rtl/bsg_lru_pseudo_tree_tracker_pkg.sv | 14 +
 rtl/bsg_lru_pseudo_tree_masked_encode.sv | 61 ++++++
 rtl/bsg_lru_pseudo_tree_tracker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bsg_lru_pseudo_tree_tracker_pkg.sv
// Shared sizing helpers for the pseudo-LRU tracker and its masked tree encoder.
// safe_clog2 keeps every index port at least one bit wide, even for a single set or way.
package bsg_lru_pseudo_tree_tracker_pkg;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Tree nodes per set. A single-way build still gets one (never written) storage bit.
    function automatic int tree_nodes(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/bsg_lru_pseudo_tree_masked_encode.sv
// Combinational pseudo-LRU tree walk that steers around fully disabled subtrees.
// Returns the way reached by following the tree bits from the root.
module bsg_lru_pseudo_tree_masked_encode
    import bsg_lru_pseudo_tree_tracker_pkg::*;
#(
    parameter int ways_p = 8,
    localparam int lg_ways_lp = safe_clog2(ways_p),
    localparam int nodes_lp = tree_nodes(ways_p)
) (
    input  logic [nodes_lp-1:0]   tree_i,
    input  logic [ways_p-1:0]     disable_i,
    output logic [lg_ways_lp-1:0] way_o
);

    localparam int levels_lp = $clog2(ways_p);

    // For each node: is the whole left (MSB=0) or right (MSB=1) child subtree disabled?
    logic [nodes_lp-1:0] left_dis;
    logic [nodes_lp-1:0] right_dis;

    generate
        if (ways_p == 1) begin : g_single
            assign left_dis  = '0;
            assign right_dis = '0;
        end

        // Level gi holds one "all disabled" flag per aligned group of 2^gi ways.
        for (genvar gi = 0; gi <= levels_lp; gi++) begin : g_lvl
            logic [(ways_p>>gi)-1:0] all_dis;
            if (gi == 0) begin : g_leaf
                assign all_dis = disable_i;
            end else begin : g_node
                for (genvar gj = 0; gj < (ways_p >> gi); gj++) begin : g_pair
                    localparam int node_lp = (1 << (levels_lp - gi)) - 1 + gj;
                    assign all_dis[gj]         = g_lvl[gi-1].all_dis[2*gj] & g_lvl[gi-1].all_dis[2*gj+1];
                    assign left_dis[node_lp]  = g_lvl[gi-1].all_dis[2*gj];
                    assign right_dis[node_lp] = g_lvl[gi-1].all_dis[2*gj+1];
                end
            end
        end
    endgenerate

    always_comb begin
        int  prefix;
        int  node;
        logic dir;
        prefix = 0;
        for (int d = 0; d < levels_lp; d++) begin
            node = (1 << d) - 1 + prefix;
            dir  = tree_i[node];
            if (!dir && left_dis[node]) begin
                dir = 1'b1;
            end else if (dir && right_dis[node]) begin
                dir = 1'b0;
            end
            prefix = 2 * prefix + int'(dir);
        end
        way_o = lg_ways_lp'(prefix);
    end

endmodule

// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// Per-set pseudo-LRU tree state with touch updates and a one-cycle victim query.
// Victim choice prefers enabled invalid ways, then walks the tree around disabled ways.
module bsg_lru_pseudo_tree_tracker
    import bsg_lru_pseudo_tree_tracker_pkg::*;
#(
    parameter int ways_p = 8,
    parameter int sets_p = 64,
    localparam int lg_ways_lp = safe_clog2(ways_p),
    localparam int lg_sets_lp = safe_clog2(sets_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  touch_v_i,
    input  logic [lg_sets_lp-1:0] touch_set_i,
    input  logic [lg_ways_lp-1:0] touch_way_i,
    input  logic                  q_v_i,
    input  logic [lg_sets_lp-1:0] q_set_i,
    input  logic [ways_p-1:0]     q_invalid_i,
    input  logic [ways_p-1:0]     q_disable_i,
    output logic                  victim_v_o,
    output logic [lg_ways_lp-1:0] victim_way_o,
    output logic                  victim_inv_o
);

    localparam int levels_lp = $clog2(ways_p);
    localparam int nodes_lp  = tree_nodes(ways_p);
    localparam int node_w_lp = safe_clog2(nodes_lp);
    localparam logic [lg_sets_lp:0] sets_lim_lp = (lg_sets_lp+1)'(sets_p);

    logic [nodes_lp-1:0] tree_q [sets_p];

    logic                  q_v_q;
    logic [lg_sets_lp-1:0] q_set_q;
    logic [ways_p-1:0]     q_inv_q;
    logic [ways_p-1:0]     q_dis_q;

    logic [nodes_lp-1:0] touch_mask;
    logic [nodes_lp-1:0] touch_val;
    logic                touch_en;

    assign touch_en = touch_v_i && ({1'b0, touch_set_i} < sets_lim_lp);

    // Each level touches exactly one node on the path and points it at the sibling subtree.
    generate
        if (ways_p > 1) begin : g_touch
            logic [nodes_lp-1:0] lvl_mask [levels_lp];
            logic [nodes_lp-1:0] lvl_val  [levels_lp];

            for (genvar gi = 0; gi < levels_lp; gi++) begin : g_lvl
                logic [node_w_lp-1:0] node;
                if (gi == 0) begin : g_root
                    assign node = '0;
                end else begin : g_inner
                    assign node = node_w_lp'((1 << gi) - 1)
                                + node_w_lp'(touch_way_i[lg_ways_lp-1 -: gi]);
                end
                assign lvl_mask[gi] = nodes_lp'(1) << node;
                assign lvl_val[gi]  = touch_way_i[lg_ways_lp-1-gi] ? '0 : lvl_mask[gi];
            end

            always_comb begin
                touch_mask = '0;
                touch_val  = '0;
                for (int l = 0; l < levels_lp; l++) begin
                    touch_mask = touch_mask | lvl_mask[l];
                    touch_val  = touch_val | lvl_val[l];
                end
            end
        end else begin : g_no_touch
            assign touch_mask = '0;
            assign touch_val  = '0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < sets_p; s++) begin
                tree_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < sets_p; s++) begin
                if (touch_en && (touch_set_i == lg_sets_lp'(s))) begin
                    tree_q[s] <= (tree_q[s] & ~touch_mask) | touch_val;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_v_q   <= 1'b0;
            q_set_q <= '0;
            q_inv_q <= '0;
            q_dis_q <= '0;
        end else begin
            q_v_q   <= q_v_i;
            q_set_q <= q_set_i;
            q_inv_q <= q_invalid_i;
            q_dis_q <= q_disable_i;
        end
    end

    // Read the current tree row, so a touch on the query's capture edge is already visible.
    logic                  q_set_ok;
    logic [nodes_lp-1:0]   row;
    logic [ways_p-1:0]     avail;
    logic [lg_ways_lp-1:0] inv_way;
    logic [lg_ways_lp-1:0] tree_way;

    assign q_set_ok = {1'b0, q_set_q} < sets_lim_lp;
    assign avail    = q_inv_q & ~q_dis_q;

    always_comb begin
        row = '0;
        for (int s = 0; s < sets_p; s++) begin
            if (q_set_q == lg_sets_lp'(s)) begin
                row = tree_q[s];
            end
        end
    end

    always_comb begin
        inv_way = '0;
        for (int w = ways_p - 1; w >= 0; w--) begin
            if (avail[w]) begin
                inv_way = lg_ways_lp'(w);
            end
        end
    end

    bsg_lru_pseudo_tree_masked_encode #(
        .ways_p (ways_p)
    ) u_encode (
        .tree_i    (row),
        .disable_i (q_dis_q),
        .way_o     (tree_way)
    );

    always_comb begin
        victim_v_o   = q_v_q && q_set_ok && !(&q_dis_q);
        victim_inv_o = victim_v_o && (|avail);
        victim_way_o = '0;
        if (victim_v_o) begin
            victim_way_o = (|avail) ? inv_way : tree_way;
        end
    end

endmodule
